// File: rtl/music_pkg.sv
// music_pkg: shared types and helpers for the music-player playback path.
// Holds the sequencer state encoding, beat index width and the start/end
// index helpers used by beat_seq_ctrl.
package music_pkg;

  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // First index shown after a load: 0 going forward, the last beat in reverse.
  function automatic logic [BEAT_W-1:0] beat_start_value(input logic rev,
                                                         input logic [BEAT_W-1:0] len);
    return rev ? len : {BEAT_W{1'b0}};
  endfunction

  // Index at which the song ends for the given direction.
  function automatic logic [BEAT_W-1:0] beat_end_value(input logic rev,
                                                       input logic [BEAT_W-1:0] len);
    return rev ? {BEAT_W{1'b0}} : len;
  endfunction

endpackage

// File: rtl/beat_seq_ctrl_divider.sv
// beat_divider: tempo prescaler for the beat sequencer.
// Counts 0..TEMPO_DIV-1 while enabled and flags the terminal count; holds its
// value while disabled so a paused song resumes mid-beat.
module beat_divider #(
  parameter int TEMPO_DIV = 12_500_000,
  parameter int CNT_W     = $clog2(TEMPO_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic             tc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TEMPO_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider counter: clear wins, otherwise count and wrap while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tc  = en && !clr && (r_cnt == LAST);
  assign cnt = r_cnt;

endmodule

// File: rtl/beat_seq_ctrl.sv
// beat_seq_ctrl: playback sequencer producing the paced beat index.
// Play/pause/stop FSM, forward/reverse stepping and end-of-song detection.
// Optional feature macro: BEAT_SEQ_LOOP_EN (wrap at song end instead of DONE).
module beat_seq_ctrl
  import music_pkg::*;
#(
  parameter int BEAT_LEN  = 28,
  parameter int TEMPO_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              dir,
  output logic [BEAT_W-1:0] ibeat,
  output logic              beat_tick,
  output logic              done,
  output logic              playing
);

  localparam int                CNT_W    = $clog2(TEMPO_DIV);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(TEMPO_DIV - 1);
  localparam logic [BEAT_W-1:0] LEN      = BEAT_W'(BEAT_LEN);

  seq_state_t        r_state;
  logic [BEAT_W-1:0] r_ibeat;
  logic              r_beat_tick;
  logic              r_done;
  logic              r_playing;

  logic              w_div_en;
  logic              w_div_clr;
  logic              w_div_tc;
  logic [CNT_W-1:0]  w_div_cnt;
  logic              w_step;
  logic              w_out_of_range;
  logic              w_at_end;
  logic [BEAT_W-1:0] w_next_beat;

  // Divider runs only in PLAY; it is held at zero whenever no song is loaded.
  assign w_div_en  = (r_state == PLAY);
  assign w_div_clr = stop || (r_state == IDLE) || (r_state == DONE);

  beat_divider #(
    .TEMPO_DIV (TEMPO_DIV),
    .CNT_W     (CNT_W)
  ) u_beat_divider (
    .clk   (clk),
    .reset (reset),
    .en    (w_div_en),
    .clr   (w_div_clr),
    .tc    (w_div_tc),
    .cnt   (w_div_cnt)
  );

  // A step is taken only when the pulse agrees with the count it reports.
  assign w_step         = w_div_tc && (w_div_cnt == DIV_LAST);
  assign w_out_of_range = (r_ibeat > LEN);
  assign w_at_end       = dir ? (r_ibeat == {BEAT_W{1'b0}}) : (r_ibeat == LEN);
  assign w_next_beat    = dir ? (r_ibeat - BEAT_W'(1)) : (r_ibeat + BEAT_W'(1));

  // Sequencer FSM with registered index, pulses and playing flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ibeat     <= {BEAT_W{1'b0}};
      r_beat_tick <= 1'b0;
      r_done      <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_beat_tick <= 1'b0;
      r_done      <= 1'b0;
      if (stop) begin
        r_state   <= IDLE;
        r_ibeat   <= {BEAT_W{1'b0}};
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (play) begin
              r_state   <= PLAY;
              r_playing <= 1'b1;
              r_ibeat   <= beat_start_value(dir, LEN);
            end
          end
          PLAY: begin
            if (w_step && (w_out_of_range || w_at_end)) begin
              r_done <= 1'b1;
`ifdef BEAT_SEQ_LOOP_EN
              if (w_out_of_range) begin
                r_ibeat <= beat_end_value(dir, LEN);
              end else begin
                r_ibeat     <= beat_start_value(dir, LEN);
                r_beat_tick <= 1'b1;
              end
              if (play) begin
                r_state   <= PAUSE;
                r_playing <= 1'b0;
              end
`else
              r_ibeat   <= beat_end_value(dir, LEN);
              r_state   <= DONE;
              r_playing <= 1'b0;
`endif
            end else begin
              if (w_step) begin
                r_ibeat     <= w_next_beat;
                r_beat_tick <= 1'b1;
              end
              if (play) begin
                r_state   <= PAUSE;
                r_playing <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (play) begin
              r_state   <= PLAY;
              r_playing <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_ibeat   <= {BEAT_W{1'b0}};
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ibeat     = r_ibeat;
  assign beat_tick = r_beat_tick;
  assign done      = r_done;
  assign playing   = r_playing;

endmodule
